// File: rtl/serial_adder_pkg.sv
// Shared helpers for the bit-serial adder slice.
package serial_adder_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  // Counter holds 0..WIDTH-1 with headroom so it never wraps inside an operation.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_adder.sv
// 1-bit full adder shared by the serial datapath.
module adder (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic SUM,
  output logic COUT
);

  assign SUM  = A ^ B ^ CIN;
  assign COUT = (A & B) | (A & CIN) | (B & CIN);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, WIDTH cycles per sum.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_cout;

  adder u_fa (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .CIN  (carry_q),
    .SUM  (fa_sum),
    .COUT (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        s_d     = {fa_sum, s_q[WIDTH-1:1]};
        carry_d = fa_cout;
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        // Last bit: publish the completed result straight from the adder output.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {fa_sum, s_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with hand-computed sums.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, wait (bounded) for done, and check latency, busy length and result.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [7:0] es, input logic ec,
                        input bit hold_start, input bit scramble);
    int n;
    int busy_cnt;
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      check({tag, "_overlap"}, {31'd0, busy & done}, 32'd0);
      @(posedge clk); #1;
      n++;
      if (scramble && n == 3) begin
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end
    end
    check({tag, "_done"},    {31'd0, done}, 32'd1);
    check({tag, "_latency"}, n,             32'd8);
    check({tag, "_busylen"}, busy_cnt,      32'd8);
    check({tag, "_busy0"},   {31'd0, busy}, 32'd0);
    check({tag, "_sum"},     {24'd0, sum},  {24'd0, es});
    check({tag, "_cout"},    {31'd0, cout}, {31'd0, ec});
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_donepulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {24'd0, sum},  32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Idle without start: nothing happens.
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);

    run_op("ff_01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("5a_a5",   8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("00_00c",  8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op("ff_ffc",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Start held through SHIFT and DONE: run_op drops it just after leaving DONE.
    run_op("hold",    8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_nobusy", {31'd0, busy}, 32'd0);
      check("hold_nodone", {31'd0, done}, 32'd0);
    end
    check("hold_sumheld", {24'd0, sum}, 32'h7E);

    // Operands scrambled mid-SHIFT must not disturb the captured values.
    run_op("scramble", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    a = 8'h99; b = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    check("hold_sum46",  {24'd0, sum},  32'h46);
    check("hold_cout46", {31'd0, cout}, 32'd0);

    // Reset in the middle of a SHIFT aborts with no done pulse.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum",  {24'd0, sum},  32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      check("abort_nodone", {31'd0, done}, 32'd0);
      check("abort_nobusy", {31'd0, busy}, 32'd0);
    end
    run_op("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
